// File: rtl/spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// spi_flash_arbiter
//
// Purpose:
//   Shares one flash word reader between two read requesters: requester 0
//   (instruction fetch) and requester 1 (data load). Ties are broken
//   round-robin. One access is in flight at a time. Each access finishes with a
//   one-cycle ready pulse to the requester that was granted.
//
// Optional feature (macro SPI_FLASH_ARB_CACHE_EN):
//   Keeps a one-entry last-read buffer (tag, word, valid). A grant whose address
//   matches the buffered tag is answered without a flash access. The flash is
//   read-only, so only rst clears the buffer's valid bit.
//
// Ports:
//   clk                    system clock; all state changes on its rising edge
//   rst                    asynchronous, active-high reset
//   m0_valid/m0_addr       requester 0 read request and word address
//   m0_ready/m0_data       requester 0 completion pulse and read word
//   m1_valid/m1_addr       requester 1 read request and word address
//   m1_ready/m1_data       requester 1 completion pulse and read word
//   fl_valid/fl_addr       request and word address to the flash reader
//   fl_ready/fl_data       completion pulse and word from the flash reader
// -----------------------------------------------------------------------------
module spi_flash_arbiter #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_ready,
   output logic [DATA_W-1:0] m0_data,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              fl_valid,
   output logic [ADDR_W-1:0] fl_addr,
   input  logic              fl_ready,
   input  logic [DATA_W-1:0] fl_data
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_reg, state_next;
   logic              grant_reg, grant_next;   // 0 = requester 0, 1 = requester 1
   logic              last_reg,  last_next;    // requester served most recently
   logic [ADDR_W-1:0] addr_reg,  addr_next;
   logic [DATA_W-1:0] data_reg,  data_next;

   logic              grant_sel;
   logic [ADDR_W-1:0] addr_sel;

`ifdef SPI_FLASH_ARB_CACHE_EN
   logic [ADDR_W-1:0] tag_reg,    tag_next;
   logic [DATA_W-1:0] word_reg,   word_next;
   logic              cvalid_reg, cvalid_next;
   // A hit still spends one cycle in BUSY (with fl_valid suppressed) so that
   // the ready pulse lands two cycles after the request, the same place it
   // would for a flash access that completes at once.
   logic              hit_reg,    hit_next;
`endif

   // Round-robin: on a tie grant whoever was not served last; a lone
   // requester is always granted.
   assign grant_sel = (m0_valid && m1_valid) ? ~last_reg : m1_valid;
   assign addr_sel  = grant_sel ? m1_addr : m0_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         grant_reg  <= 1'b0;
         last_reg   <= 1'b1;    // requester 0 wins the first tie
         addr_reg   <= '0;
         data_reg   <= '0;
`ifdef SPI_FLASH_ARB_CACHE_EN
         tag_reg    <= '0;
         word_reg   <= '0;
         cvalid_reg <= 1'b0;
         hit_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         last_reg   <= last_next;
         addr_reg   <= addr_next;
         data_reg   <= data_next;
`ifdef SPI_FLASH_ARB_CACHE_EN
         tag_reg    <= tag_next;
         word_reg   <= word_next;
         cvalid_reg <= cvalid_next;
         hit_reg    <= hit_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      last_next   = last_reg;
      addr_next   = addr_reg;
      data_next   = data_reg;
`ifdef SPI_FLASH_ARB_CACHE_EN
      tag_next    = tag_reg;
      word_next   = word_reg;
      cvalid_next = cvalid_reg;
      hit_next    = hit_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               grant_next = grant_sel;
               addr_next  = addr_sel;
               state_next = BUSY;
`ifdef SPI_FLASH_ARB_CACHE_EN
               if (cvalid_reg && (tag_reg == addr_sel)) begin
                  hit_next  = 1'b1;
                  data_next = word_reg;
               end
`endif
            end
         end
         BUSY: begin
`ifdef SPI_FLASH_ARB_CACHE_EN
            if (hit_reg) begin
               state_next = DONE;
            end else if (fl_ready) begin
               data_next   = fl_data;
               tag_next    = addr_reg;
               word_next   = fl_data;
               cvalid_next = 1'b1;
               state_next  = DONE;
            end
`else
            if (fl_ready) begin
               data_next  = fl_data;
               state_next = DONE;
            end
`endif
         end
         DONE: begin
            last_next  = grant_reg;
            state_next = IDLE;
`ifdef SPI_FLASH_ARB_CACHE_EN
            hit_next   = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // Decoded straight from the state register so that rst drops fl_valid
   // without waiting for a clock edge.
`ifdef SPI_FLASH_ARB_CACHE_EN
   assign fl_valid = (state_reg == BUSY) && !hit_reg;
`else
   assign fl_valid = (state_reg == BUSY);
`endif
   assign fl_addr  = addr_reg;
   assign m0_ready = (state_reg == DONE) && !grant_reg;
   assign m1_ready = (state_reg == DONE) &&  grant_reg;
   assign m0_data  = data_reg;
   assign m1_data  = data_reg;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              m0_valid, m1_valid;
   logic [ADDR_W-1:0] m0_addr,  m1_addr;
   logic              m0_ready, m1_ready;
   logic [DATA_W-1:0] m0_data,  m1_data;
   logic              fl_valid;
   logic [ADDR_W-1:0] fl_addr;
   logic              fl_ready;
   logic [DATA_W-1:0] fl_data;

   int n_tests = 0;
   int n_fail  = 0;

   spi_flash_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_valid (m0_valid),
      .m0_addr  (m0_addr),
      .m0_ready (m0_ready),
      .m0_data  (m0_data),
      .m1_valid (m1_valid),
      .m1_addr  (m1_addr),
      .m1_ready (m1_ready),
      .m1_data  (m1_data),
      .fl_valid (fl_valid),
      .fl_addr  (fl_addr),
      .fl_ready (fl_ready),
      .fl_data  (fl_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock cycle: inputs driven at the falling edge, expected
   // outputs for that same cycle (outputs depend only on registered state).
   typedef struct {
      logic              rst;
      logic              m0v;
      logic [ADDR_W-1:0] m0a;
      logic              m1v;
      logic [ADDR_W-1:0] m1a;
      logic              flr;
      logic [DATA_W-1:0] fld;
      logic              e_flv;
      logic [ADDR_W-1:0] e_fla;
      logic              e_m0r;
      logic              e_m1r;
      logic              chk_d;
      logic [DATA_W-1:0] e_d;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int unsigned r, m0v, m0a, m1v, m1a, flr, fld,
                               eflv, efla, em0r, em1r, chkd, ed);
      vec_t v;
      v.rst   = r[0];
      v.m0v   = m0v[0];
      v.m0a   = m0a[ADDR_W-1:0];
      v.m1v   = m1v[0];
      v.m1a   = m1a[ADDR_W-1:0];
      v.flr   = flr[0];
      v.fld   = fld;
      v.e_flv = eflv[0];
      v.e_fla = efla[ADDR_W-1:0];
      v.e_m0r = em0r[0];
      v.e_m1r = em1r[0];
      v.chk_d = chkd[0];
      v.e_d   = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Full read through the flash: request, wait (bounded) for fl_valid,
   // answer with word, check the ready pulse. Leaves the bench in the DONE
   // cycle with the request dropped.
   task automatic do_read(input string name, input logic sel,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] word);
      bit seen;
      @(negedge clk);
      m0_valid = !sel; m0_addr = sel ? '0 : addr;
      m1_valid =  sel; m1_addr = sel ? addr : '0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk); #1;
         if (fl_valid) seen = 1'b1;
      end
      chk({name, "_flv_seen"}, 32'(seen), 32'd1);
      chk({name, "_fl_addr"}, 32'(fl_addr), 32'(addr));
      fl_ready = 1'b1; fl_data = word;
      @(negedge clk);
      fl_ready = 1'b0; fl_data = '0;
      #1;
      chk({name, "_m0_ready"}, 32'(m0_ready), 32'(!sel));
      chk({name, "_m1_ready"}, 32'(m1_ready), 32'(sel));
      chk({name, "_data"}, sel ? m1_data : m0_data, word);
      m0_valid = 1'b0; m1_valid = 1'b0;
      $display("[TB] read %s addr=0x%06h data=0x%08h", name, addr, sel ? m1_data : m0_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_valid = 1'b0; m0_addr = '0;
      m1_valid = 1'b0; m1_addr = '0;
      fl_ready = 1'b0; fl_data = '0;

      // Request/flash traffic, one record per cycle.
      // single m0 read, then spurious fl_ready in IDLE
      vecs.push_back(mk(0,1,'h10,0,0,0,0,                 0,0,0,0,0,0));
      vecs.push_back(mk(0,1,'h10,0,0,0,0,                 1,'h10,0,0,0,0));
      vecs.push_back(mk(0,1,'h10,0,0,1,32'hDEADBEEF,      1,'h10,0,0,0,0));
      vecs.push_back(mk(0,1,'h10,0,0,0,0,                 0,0,1,0,1,32'hDEADBEEF));
      vecs.push_back(mk(0,0,0,0,0,1,32'hBAD0BAD0,         0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,0,0,1,32'hDEADBEEF));
      // reset, then simultaneous pair: m0 first, re-tie -> m1, then m0
      vecs.push_back(mk(1,0,0,0,0,0,0,                    0,0,0,0,1,0));
      vecs.push_back(mk(0,1,'h100,1,'h200,0,0,            0,0,0,0,0,0));
      vecs.push_back(mk(0,1,'h100,1,'h200,1,32'h11111111, 1,'h100,0,0,0,0));
      vecs.push_back(mk(0,1,'h300,1,'h200,0,0,            0,0,1,0,1,32'h11111111));
      vecs.push_back(mk(0,1,'h300,1,'h200,0,0,            0,0,0,0,0,0));
      vecs.push_back(mk(0,1,'h300,1,'h200,0,0,            1,'h200,0,0,0,0));
      vecs.push_back(mk(0,1,'h300,1,'h200,1,32'h22222222, 1,'h200,0,0,0,0));
      vecs.push_back(mk(0,1,'h300,0,0,0,0,                0,0,0,1,1,32'h22222222));
      vecs.push_back(mk(0,1,'h300,0,0,0,0,                0,0,0,0,0,0));
      vecs.push_back(mk(0,1,'h300,0,0,1,32'h33333333,     1,'h300,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,1,0,1,32'h33333333));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,0,0,0,0));
      // m1 arrives while m0 is in BUSY; gap cycle with fl_valid low
      vecs.push_back(mk(0,1,'h40,0,0,0,0,                 0,0,0,0,0,0));
      vecs.push_back(mk(0,1,'h40,1,'h50,0,0,              1,'h40,0,0,0,0));
      vecs.push_back(mk(0,1,'h40,1,'h50,1,32'h44444444,   1,'h40,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,'h50,0,0,                 0,0,1,0,1,32'h44444444));
      vecs.push_back(mk(0,0,0,1,'h50,0,0,                 0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,'h50,1,32'h55555555,      1,'h50,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,0,1,1,32'h55555555));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,0,0,0,0));
      // granted requester drops valid in BUSY: access still completes
      vecs.push_back(mk(0,1,'h80,0,0,0,0,                 0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    1,'h80,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,32'h66666666,         1,'h80,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,1,0,1,32'h66666666));
      vecs.push_back(mk(0,0,0,0,0,0,0,                    0,0,0,0,0,0));

      // Reset state
      #1;
      chk("rst_fl_valid", 32'(fl_valid), 32'd0);
      chk("rst_fl_addr",  32'(fl_addr),  32'd0);
      chk("rst_m0_ready", 32'(m0_ready), 32'd0);
      chk("rst_m1_ready", 32'(m1_ready), 32'd0);
      chk("rst_data",     m0_data,       32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         rst      = vecs[i].rst;
         m0_valid = vecs[i].m0v;  m0_addr = vecs[i].m0a;
         m1_valid = vecs[i].m1v;  m1_addr = vecs[i].m1a;
         fl_ready = vecs[i].flr;  fl_data = vecs[i].fld;
         #1;
         chk($sformatf("vec%0d_fl_valid", i), 32'(fl_valid), 32'(vecs[i].e_flv));
         chk($sformatf("vec%0d_m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_m0r));
         chk($sformatf("vec%0d_m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_m1r));
         if (vecs[i].e_flv || vecs[i].rst)
            chk($sformatf("vec%0d_fl_addr", i), 32'(fl_addr), 32'(vecs[i].e_fla));
         if (vecs[i].chk_d) begin
            chk($sformatf("vec%0d_m0_data", i), m0_data, vecs[i].e_d);
            chk($sformatf("vec%0d_m1_data", i), m1_data, vecs[i].e_d);
         end
         $display("[TB] vec %0d flv=%0b m0r=%0b m1r=%0b data=0x%08h",
                  i, fl_valid, m0_ready, m1_ready, m0_data);
      end

      // Reset three cycles into BUSY aborts the access
      @(negedge clk);
      m0_valid = 1'b1; m0_addr = 22'h60;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("abort_busy%0d_flv", c), 32'(fl_valid), 32'd1);
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_async_flv", 32'(fl_valid), 32'd0);
      chk("abort_async_m0r", 32'(m0_ready), 32'd0);
      @(negedge clk);
      m0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         chk($sformatf("abort_after%0d_m0r", c), 32'(m0_ready), 32'd0);
         chk($sformatf("abort_after%0d_flv", c), 32'(fl_valid), 32'd0);
      end
      do_read("after_abort", 1'b0, 22'h70, 32'h77777777);

      // Repeat read of the top address
      do_read("top_first", 1'b1, 22'h3FFFFF, 32'hCAFEF00D);
      @(negedge clk);
      m1_valid = 1'b1; m1_addr = 22'h3FFFFF;          // request cycle T
      @(negedge clk); #1;                               // T+1
`ifdef SPI_FLASH_ARB_CACHE_EN
      chk("hit_t1_flv", 32'(fl_valid), 32'd0);
      chk("hit_t1_m1r", 32'(m1_ready), 32'd0);
      @(negedge clk); #1;                               // T+2
      chk("hit_t2_flv",  32'(fl_valid), 32'd0);
      chk("hit_t2_m1r",  32'(m1_ready), 32'd1);
      chk("hit_t2_data", m1_data,       32'hCAFEF00D);
`else
      chk("nocache_t1_flv",  32'(fl_valid), 32'd1);
      chk("nocache_t1_addr", 32'(fl_addr),  32'h3FFFFF);
      fl_ready = 1'b1; fl_data = 32'h0BADF00D;
      @(negedge clk);
      fl_ready = 1'b0; fl_data = '0;
      #1;                                               // T+2
      chk("nocache_t2_m1r",  32'(m1_ready), 32'd1);
      chk("nocache_t2_data", m1_data,       32'h0BADF00D);
`endif
      m1_valid = 1'b0;
      $display("[TB] read top_second addr=0x3fffff data=0x%08h", m1_data);
      do_read("addr_zero", 1'b0, 22'h000000, 32'h12345678);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
